// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared types and constants for the single-issue scoreboard controller.
//   reg_idx_t   : architectural register index (x0..x31)
//   fu_id_t     : functional-unit id
//   issue_pkt_t : fields carried from decode to the issue register
// -----------------------------------------------------------------------------
package sb_pkg;

   localparam int NUM_REGS  = 32;
   localparam int REG_W     = 5;
   localparam int SB_NUM_FU = 4;
   localparam int SB_FU_W   = 2;

   localparam logic [REG_W-1:0] REG_X0 = '0;

   typedef logic [REG_W-1:0]   reg_idx_t;
   typedef logic [SB_FU_W-1:0] fu_id_t;

   typedef struct packed {
      fu_id_t      fu;
      reg_idx_t    rs1;
      reg_idx_t    rs2;
      reg_idx_t    rd;
      logic        wr_rd;
      logic [31:0] imm;
   } issue_pkt_t;

endpackage : sb_pkg

// File: rtl/sb_busy_table.sv
// -----------------------------------------------------------------------------
// sb_busy_table
// Busy bitmap with one set port and NUM_WB clear (writeback) ports.
// The clears are applied combinationally first, giving o_eff_busy, so that a
// consumer checking hazards sees a resource as free in the same cycle it
// completes. The set is applied on top of that, so set beats clear when both
// name the same entry. Indices >= ENTRIES are ignored on both ports.
//
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset (clears all entries)
//   i_set_valid      mark entry i_set_idx busy at the next edge
//   i_set_idx        entry to mark busy
//   i_clr_valid      one bit per writeback port
//   i_clr_idx        packed entry index per writeback port
//   o_busy           registered busy bitmap
//   o_eff_busy       busy bitmap with this cycle's clears already applied
// -----------------------------------------------------------------------------
module sb_busy_table #(
   parameter int ENTRIES = 32,
   parameter int NUM_WB  = 2,
   parameter int IDX_W   = 5
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_set_valid,
   input  logic [IDX_W-1:0]        i_set_idx,
   input  logic [NUM_WB-1:0]       i_clr_valid,
   input  logic [NUM_WB*IDX_W-1:0] i_clr_idx,
   output logic [ENTRIES-1:0]      o_busy,
   output logic [ENTRIES-1:0]      o_eff_busy
);

   logic [ENTRIES-1:0] busy_q;
   logic [ENTRIES-1:0] busy_d;
   logic [ENTRIES-1:0] eff_busy;

   always_comb begin
      eff_busy = busy_q;
      // Several ports naming the same entry simply clear it once.
      for (int p = 0; p < NUM_WB; p++) begin
         for (int e = 0; e < ENTRIES; e++) begin
            if (i_clr_valid[p] && (i_clr_idx[p*IDX_W +: IDX_W] == IDX_W'(e))) begin
               eff_busy[e] = 1'b0;
            end
         end
      end

      busy_d = eff_busy;
      for (int e = 0; e < ENTRIES; e++) begin
         if (i_set_valid && (i_set_idx == IDX_W'(e))) begin
            busy_d[e] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_eff_busy = eff_busy;

endmodule : sb_busy_table

// File: rtl/sb_issue_ctrl.sv
// -----------------------------------------------------------------------------
// sb_issue_ctrl
// Single-issue scoreboard controller. Accepts one decoded instruction per
// cycle, stalls it on RAW / WAW / structural hazards against the register and
// FU busy tables, and issues it one cycle after acceptance. Writebacks free
// registers and FUs and bypass into the same-cycle hazard check.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_dec_*                 decoded instruction offered by decode
//   o_dec_ready             combinational accept (independent of i_dec_valid)
//   i_flush                 kill the instruction currently offered
//   o_iss_*                 registered issue pulse and payload (payload holds
//                           its last value between issues)
//   i_wb_*                  NUM_WB packed writeback/completion ports
//   o_reg_busy, o_fu_busy   busy bitmaps
//   o_stall_cnt             saturating count of hazard-stalled cycles
//
// The issue packet struct is sized by the package FU width, so FU_W is
// expected to match sb_pkg::SB_FU_W.
// -----------------------------------------------------------------------------
module sb_issue_ctrl
   import sb_pkg::*;
#(
   parameter int NUM_FU = SB_NUM_FU,
   parameter int FU_W   = SB_FU_W,
   parameter int NUM_WB = 2,
   parameter int CNT_W  = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,

   input  logic                 i_dec_valid,
   output logic                 o_dec_ready,
   input  logic [4:0]           i_dec_rs1,
   input  logic [4:0]           i_dec_rs2,
   input  logic [4:0]           i_dec_rd,
   input  logic                 i_dec_use_rs1,
   input  logic                 i_dec_use_rs2,
   input  logic                 i_dec_wr_rd,
   input  logic [FU_W-1:0]      i_dec_fu,
   input  logic [31:0]          i_dec_imm,
   input  logic                 i_flush,

   output logic                 o_iss_valid,
   output logic [FU_W-1:0]      o_iss_fu,
   output logic [4:0]           o_iss_rs1,
   output logic [4:0]           o_iss_rs2,
   output logic [4:0]           o_iss_rd,
   output logic                 o_iss_wr_rd,
   output logic [31:0]          o_iss_imm,

   input  logic [NUM_WB-1:0]      i_wb_valid,
   input  logic [NUM_WB*FU_W-1:0] i_wb_fu,
   input  logic [NUM_WB*5-1:0]    i_wb_rd,
   input  logic [NUM_WB-1:0]      i_wb_wr_rd,

   output logic [31:0]          o_reg_busy,
   output logic [NUM_FU-1:0]    o_fu_busy,
   output logic [CNT_W-1:0]     o_stall_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [NUM_REGS-1:0] reg_busy;
   logic [NUM_REGS-1:0] eff_reg_busy;
   logic [NUM_FU-1:0]   fu_busy;
   logic [NUM_FU-1:0]   eff_fu_busy;
   logic [NUM_WB-1:0]   reg_clr_valid;

   logic raw_haz;
   logic waw_haz;
   logic struct_haz;
   logic dec_ready;
   logic accept;
   logic reg_set;

   issue_pkt_t         dec_pkt;
   issue_pkt_t         iss_pkt_q;
   issue_pkt_t         iss_pkt_d;
   logic               iss_valid_q;
   logic               iss_valid_d;
   logic [CNT_W-1:0]   stall_cnt_q;
   logic [CNT_W-1:0]   stall_cnt_d;

   // Only completions that actually write a register free one.
   assign reg_clr_valid = i_wb_valid & i_wb_wr_rd;

   sb_busy_table #(
      .ENTRIES (NUM_REGS),
      .NUM_WB  (NUM_WB),
      .IDX_W   (REG_W)
   ) u_reg_table (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_set_valid (reg_set),
      .i_set_idx   (i_dec_rd),
      .i_clr_valid (reg_clr_valid),
      .i_clr_idx   (i_wb_rd),
      .o_busy      (reg_busy),
      .o_eff_busy  (eff_reg_busy)
   );

   sb_busy_table #(
      .ENTRIES (NUM_FU),
      .NUM_WB  (NUM_WB),
      .IDX_W   (FU_W)
   ) u_fu_table (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_set_valid (accept),
      .i_set_idx   (i_dec_fu),
      .i_clr_valid (i_wb_valid),
      .i_clr_idx   (i_wb_fu),
      .o_busy      (fu_busy),
      .o_eff_busy  (eff_fu_busy)
   );

   // Hazard check against the bypassed (post-writeback) view of the tables.
   always_comb begin
      raw_haz = (i_dec_use_rs1 && (i_dec_rs1 != REG_X0) && eff_reg_busy[i_dec_rs1]) ||
                (i_dec_use_rs2 && (i_dec_rs2 != REG_X0) && eff_reg_busy[i_dec_rs2]);
      waw_haz = i_dec_wr_rd && (i_dec_rd != REG_X0) && eff_reg_busy[i_dec_rd];

      // An id with no matching FU keeps struct_haz set, so it can never issue.
      struct_haz = 1'b1;
      for (int e = 0; e < NUM_FU; e++) begin
         if (i_dec_fu == FU_W'(e)) begin
            struct_haz = eff_fu_busy[e];
         end
      end

      dec_ready = !(raw_haz || waw_haz || struct_haz) && !i_flush;
   end

   assign accept  = i_dec_valid && dec_ready;
   assign reg_set = accept && i_dec_wr_rd && (i_dec_rd != REG_X0);

   always_comb begin
      dec_pkt       = '0;
      dec_pkt.fu    = i_dec_fu;
      dec_pkt.rs1   = i_dec_rs1;
      dec_pkt.rs2   = i_dec_rs2;
      dec_pkt.rd    = i_dec_rd;
      dec_pkt.wr_rd = i_dec_wr_rd;
      dec_pkt.imm   = i_dec_imm;

      iss_valid_d = accept;
      iss_pkt_d   = accept ? dec_pkt : iss_pkt_q;

      // A flushed offer is not a hazard stall and is not counted.
      stall_cnt_d = stall_cnt_q;
      if (i_dec_valid && !dec_ready && !i_flush) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end
   end

   // ---- issue register: decode -> FU, one cycle ----
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         iss_valid_q <= 1'b0;
         iss_pkt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         iss_valid_q <= iss_valid_d;
         iss_pkt_q   <= iss_pkt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_dec_ready = dec_ready;
   assign o_iss_valid = iss_valid_q;
   assign o_iss_fu    = iss_pkt_q.fu;
   assign o_iss_rs1   = iss_pkt_q.rs1;
   assign o_iss_rs2   = iss_pkt_q.rs2;
   assign o_iss_rd    = iss_pkt_q.rd;
   assign o_iss_wr_rd = iss_pkt_q.wr_rd;
   assign o_iss_imm   = iss_pkt_q.imm;
   assign o_reg_busy  = reg_busy;
   assign o_fu_busy   = fu_busy;
   assign o_stall_cnt = stall_cnt_q;

endmodule : sb_issue_ctrl

// File: tb/tb_sb_issue_ctrl.sv
module tb_sb_issue_ctrl;

   localparam int NUM_FU = 4;
   localparam int FU_W   = 2;
   localparam int NUM_WB = 2;
   localparam int CNT_W  = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n;
   logic                 dec_valid;
   logic                 dec_ready;
   logic [4:0]           dec_rs1, dec_rs2, dec_rd;
   logic                 dec_use_rs1, dec_use_rs2, dec_wr_rd;
   logic [FU_W-1:0]      dec_fu;
   logic [31:0]          dec_imm;
   logic                 flush;
   logic                 iss_valid;
   logic [FU_W-1:0]      iss_fu;
   logic [4:0]           iss_rs1, iss_rs2, iss_rd;
   logic                 iss_wr_rd;
   logic [31:0]          iss_imm;
   logic [NUM_WB-1:0]    wb_valid;
   logic [NUM_WB*FU_W-1:0] wb_fu;
   logic [NUM_WB*5-1:0]  wb_rd;
   logic [NUM_WB-1:0]    wb_wr_rd;
   logic [31:0]          reg_busy;
   logic [NUM_FU-1:0]    fu_busy;
   logic [CNT_W-1:0]     stall_cnt;

   sb_issue_ctrl #(
      .NUM_FU (NUM_FU), .FU_W (FU_W), .NUM_WB (NUM_WB), .CNT_W (CNT_W)
   ) dut (
      .i_clk (clk), .i_rst_n (rst_n),
      .i_dec_valid (dec_valid), .o_dec_ready (dec_ready),
      .i_dec_rs1 (dec_rs1), .i_dec_rs2 (dec_rs2), .i_dec_rd (dec_rd),
      .i_dec_use_rs1 (dec_use_rs1), .i_dec_use_rs2 (dec_use_rs2),
      .i_dec_wr_rd (dec_wr_rd), .i_dec_fu (dec_fu), .i_dec_imm (dec_imm),
      .i_flush (flush),
      .o_iss_valid (iss_valid), .o_iss_fu (iss_fu), .o_iss_rs1 (iss_rs1),
      .o_iss_rs2 (iss_rs2), .o_iss_rd (iss_rd), .o_iss_wr_rd (iss_wr_rd),
      .o_iss_imm (iss_imm),
      .i_wb_valid (wb_valid), .i_wb_fu (wb_fu), .i_wb_rd (wb_rd),
      .i_wb_wr_rd (wb_wr_rd),
      .o_reg_busy (reg_busy), .o_fu_busy (fu_busy), .o_stall_cnt (stall_cnt)
   );

   typedef struct {
      bit [FU_W-1:0] fu;
      bit [4:0]      rs1;
      bit [4:0]      rs2;
      bit [4:0]      rd;
      bit            wr;
      bit [31:0]     imm;
   } pkt_t;

   int total = 0;
   int bad   = 0;

   // Reference model: which registers / FUs are in flight, and the stall count.
   bit              m_reg[32];
   bit              m_fu[NUM_FU];
   longint unsigned m_stall;
   pkt_t            exp_q[$];
   pkt_t            last_pkt;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_reg_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_reg[i];
      return v;
   endfunction

   function automatic logic [NUM_FU-1:0] model_fu_vec();
      logic [NUM_FU-1:0] v;
      for (int i = 0; i < NUM_FU; i++) v[i] = m_fu[i];
      return v;
   endfunction

   // Called just after a falling edge with the cycle's inputs already driven.
   // Predicts this cycle's ready/accept, advances the model to the state the
   // next rising edge should produce, then checks the tables on the next fall.
   task automatic do_cycle();
      bit   er[32];
      bit   ef[NUM_FU];
      bit   raw, waw, st, rdy, acc;
      int   f;
      pkt_t p;
      #1;
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_reg[i] = 1'b0;
         for (int i = 0; i < NUM_FU; i++) m_fu[i] = 1'b0;
         m_stall = 0;
         exp_q.delete();
         last_pkt = '{default: 0};
      end else begin
         er = m_reg;
         ef = m_fu;
         for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k] && wb_wr_rd[k]) er[wb_rd[k*5 +: 5]] = 1'b0;
            f = int'(wb_fu[k*FU_W +: FU_W]);
            if (wb_valid[k] && f < NUM_FU) ef[f] = 1'b0;
         end
         raw = (dec_use_rs1 && dec_rs1 != 0 && er[dec_rs1]) ||
               (dec_use_rs2 && dec_rs2 != 0 && er[dec_rs2]);
         waw = dec_wr_rd && dec_rd != 0 && er[dec_rd];
         f   = int'(dec_fu);
         st  = (f >= NUM_FU) ? 1'b1 : ef[f];
         rdy = !(raw || waw || st) && !flush;
         chk("dec_ready", {63'd0, dec_ready}, {63'd0, rdy});
         acc = dec_valid && rdy;
         if (acc) begin
            p.fu = dec_fu; p.rs1 = dec_rs1; p.rs2 = dec_rs2;
            p.rd = dec_rd; p.wr = dec_wr_rd; p.imm = dec_imm;
            exp_q.push_back(p);
            ef[f] = 1'b1;
            if (dec_wr_rd && dec_rd != 0) er[dec_rd] = 1'b1;
         end
         if (dec_valid && !rdy && !flush && m_stall != 64'hFFFF_FFFF) m_stall++;
         m_reg = er;
         m_fu  = ef;
      end
      @(negedge clk);
      chk("reg_busy",  {32'd0, reg_busy},  {32'd0, model_reg_vec()});
      chk("fu_busy",   {60'd0, fu_busy},   {60'd0, model_fu_vec()});
      chk("stall_cnt", {32'd0, stall_cnt}, m_stall);
   endtask

   // Monitor: every issue pulse must match the oldest expected packet; with no
   // pulse, nothing may be pending and the payload must hold its last value.
   initial begin
      pkt_t e;
      forever begin
         @(posedge clk);
         #1;
         if (iss_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_issue", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("iss_fu",  {62'd0, iss_fu},    {62'd0, e.fu});
               chk("iss_rs1", {59'd0, iss_rs1},   {59'd0, e.rs1});
               chk("iss_rs2", {59'd0, iss_rs2},   {59'd0, e.rs2});
               chk("iss_rd",  {59'd0, iss_rd},    {59'd0, e.rd});
               chk("iss_wr",  {63'd0, iss_wr_rd}, {63'd0, e.wr});
               chk("iss_imm", {32'd0, iss_imm},   {32'd0, e.imm});
               last_pkt = e;
            end
         end else begin
            if (exp_q.size() != 0) begin
               chk("missed_issue", 64'd0, 64'd1);
               void'(exp_q.pop_front());
            end
            chk("hold_payload",
                {22'd0, iss_fu, iss_rs1, iss_rs2, iss_rd, iss_wr_rd, iss_imm},
                {22'd0, last_pkt.fu, last_pkt.rs1, last_pkt.rs2, last_pkt.rd,
                 last_pkt.wr, last_pkt.imm});
         end
      end
   end

   task automatic offer(bit v, int fu, int rs1, bit u1, int rs2, bit u2, int rd, bit wr);
      dec_valid   = v;
      dec_fu      = FU_W'(fu);
      dec_rs1     = 5'(rs1);
      dec_use_rs1 = u1;
      dec_rs2     = 5'(rs2);
      dec_use_rs2 = u2;
      dec_rd      = 5'(rd);
      dec_wr_rd   = wr;
      dec_imm     = $urandom();
   endtask

   task automatic wb(int k, bit v, int fu, int rd, bit wr);
      wb_valid[k]              = v;
      wb_fu[k*FU_W +: FU_W]    = FU_W'(fu);
      wb_rd[k*5 +: 5]          = 5'(rd);
      wb_wr_rd[k]              = wr;
   endtask

   task automatic clr_wb();
      wb_valid = '0; wb_fu = '0; wb_rd = '0; wb_wr_rd = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      last_pkt = '{default: 0};
      m_stall = 0;
      for (int i = 0; i < 32; i++) m_reg[i] = 1'b0;
      for (int i = 0; i < NUM_FU; i++) m_fu[i] = 1'b0;
      offer(0, 0, 0, 0, 0, 0, 0, 0);
      clr_wb();
      @(negedge clk);

      // Reset held for two cycles.
      do_cycle();
      do_cycle();
      chk("rst_iss_valid", {63'd0, iss_valid}, 64'd0);
      chk("rst_reg_busy",  {32'd0, reg_busy},  64'd0);
      chk("rst_stall",     {32'd0, stall_cnt}, 64'd0);
      rst_n = 1'b1;

      // Basic issue: add x5 on fu0.
      offer(1, 0, 1, 1, 2, 1, 5, 1);
      do_cycle();
      chk("basic_iss_valid", {63'd0, iss_valid}, 64'd1);
      chk("basic_rd5_busy",  {63'd0, reg_busy[5]}, 64'd1);
      chk("basic_fu0_busy",  {63'd0, fu_busy[0]},  64'd1);

      // RAW on x5 for three cycles, then writeback bypass releases it.
      offer(1, 1, 5, 1, 0, 0, 6, 1);
      repeat (3) do_cycle();
      chk("raw_stall3", {32'd0, stall_cnt}, 64'd3);
      wb(0, 1, 0, 5, 1);
      do_cycle();
      chk("bypass_iss_valid", {63'd0, iss_valid}, 64'd1);
      chk("bypass_rd5_free",  {63'd0, reg_busy[5]}, 64'd0);
      clr_wb();

      // WAW on x7, then structural hazard on fu2.
      offer(1, 2, 0, 0, 0, 0, 7, 1);
      do_cycle();
      offer(1, 3, 0, 0, 0, 0, 7, 1);
      repeat (2) do_cycle();
      offer(1, 2, 0, 0, 0, 0, 9, 1);
      repeat (2) do_cycle();
      chk("waw_struct_stall", {32'd0, stall_cnt}, 64'd7);
      wb(0, 1, 2, 7, 1);
      do_cycle();
      clr_wb();
      offer(1, 3, 0, 0, 0, 0, 0, 1);
      do_cycle();
      chk("x0_never_busy", {63'd0, reg_busy[0]}, 64'd0);

      // Drain, including two ports clearing in the same cycle.
      offer(0, 0, 0, 0, 0, 0, 0, 0);
      wb(0, 1, 1, 6, 1);
      wb(1, 1, 2, 9, 1);
      do_cycle();
      wb(0, 1, 3, 0, 1);
      wb(1, 1, 3, 0, 1);
      do_cycle();
      clr_wb();

      // Dual writeback plus issue reusing x3/fu0 in the same cycle.
      offer(1, 0, 0, 0, 0, 0, 3, 1);
      do_cycle();
      offer(1, 1, 0, 0, 0, 0, 4, 1);
      do_cycle();
      wb(0, 1, 0, 3, 1);
      wb(1, 1, 1, 4, 1);
      offer(1, 0, 0, 0, 0, 0, 3, 1);
      do_cycle();
      clr_wb();
      chk("dual_rd3_set",   {63'd0, reg_busy[3]}, 64'd1);
      chk("dual_rd4_clear", {63'd0, reg_busy[4]}, 64'd0);
      chk("dual_fu0_set",   {63'd0, fu_busy[0]},  64'd1);

      // Flush a hazard-free instruction.
      offer(1, 2, 0, 0, 0, 0, 10, 1);
      flush = 1'b1;
      do_cycle();
      flush = 1'b0;
      chk("flush_no_issue", {63'd0, iss_valid}, 64'd0);
      chk("flush_stall",    {32'd0, stall_cnt}, 64'd7);

      // Reset mid-operation with x5/fu1 and x3/fu0 in flight.
      offer(1, 1, 0, 0, 0, 0, 5, 1);
      do_cycle();
      offer(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      do_cycle();
      chk("midrst_reg", {32'd0, reg_busy}, 64'd0);
      chk("midrst_fu",  {60'd0, fu_busy},  64'd0);
      rst_n = 1'b1;

      // Randomised traffic with small register / FU ranges to force hazards.
      for (int n = 0; n < 3000; n++) begin
         rst_n = ($urandom_range(0, 249) != 0);
         offer($urandom_range(0, 3) != 0, $urandom_range(0, NUM_FU - 1),
               $urandom_range(0, 7), $urandom_range(0, 1) != 0,
               $urandom_range(0, 7), $urandom_range(0, 1) != 0,
               $urandom_range(0, 7), $urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 9) == 0);
         for (int k = 0; k < NUM_WB; k++) begin
            wb(k, $urandom_range(0, 9) < 4, $urandom_range(0, NUM_FU - 1),
               $urandom_range(0, 7), $urandom_range(0, 3) != 0);
         end
         do_cycle();
      end

      rst_n = 1'b1;
      flush = 1'b0;
      offer(0, 0, 0, 0, 0, 0, 0, 0);
      clr_wb();
      do_cycle();
      do_cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_sb_issue_ctrl
